// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and widths for the I/D-cache memory arbiter.
//   - state_t   : arbiter FSM states (IDLE, GNT_I, GNT_D)
//   - GNT_*     : encodings of the grant debug output
//   - MEM_*     : default block address and data widths
package mem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 28;
    localparam int unsigned MEM_DATA_WIDTH = 128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/arb_rr2.sv
// Two-way pick between I-cache and D-cache with the last-grant history.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_req_i, i_req_d  requester is asking for the memory port
//   i_accept          the FSM takes the current pick this cycle
//   o_pick_i_c        combinational: I wins the current pick
//   o_pick_d_c        combinational: D wins the current pick
module arb_rr2 #(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_accept,
    output logic o_pick_i_c,
    output logic o_pick_d_c
);

    // 1 = D was granted last; reset to D so the first tie goes to I.
    logic r_last_d;

    // Pick: single requester wins outright; a tie goes to D (fixed) or to
    // whichever side did not win last time (round-robin).
    always_comb begin
        o_pick_i_c = 1'b0;
        o_pick_d_c = 1'b0;
        if (i_req_i && i_req_d) begin
            if ((FIXED_PRIORITY != 0) || !r_last_d) begin
                o_pick_d_c = 1'b1;
            end else begin
                o_pick_i_c = 1'b1;
            end
        end else begin
            o_pick_i_c = i_req_i;
            o_pick_d_c = i_req_d;
        end
    end

    // History only moves when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b1;
        end else if (i_accept) begin
            r_last_d <= o_pick_d_c;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory block port between the I-cache and the D-cache.
// One transaction in flight; the owner is locked from acceptance until
// mem_ready or until the owner drops its request (abort).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_mem_* / d_mem_*             cache-side request/response per requester
//   mem_read/write/addr/wdata     downstream request (muxed from the owner)
//   mem_rdata, mem_ready          downstream response
//   grant                         current owner: 00 none, 01 I, 10 D
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = MEM_DATA_WIDTH,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_wdata,
    output logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  i_mem_ready,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_addr,
    input  logic [DATA_WIDTH-1:0] d_mem_wdata,
    output logic [DATA_WIDTH-1:0] d_mem_rdata,
    output logic                  d_mem_ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [1:0]            grant
);

    state_t     r_state;
    logic [1:0] r_grant;

    logic w_req_i;
    logic w_req_d;
    logic w_pick_i;
    logic w_pick_d;
    logic w_accept;

    assign w_req_i  = i_mem_read | i_mem_write;
    assign w_req_d  = d_mem_read | d_mem_write;
    assign w_accept = (r_state == S_IDLE) && (w_pick_i || w_pick_d);

    arb_rr2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_i    (w_req_i),
        .i_req_d    (w_req_d),
        .i_accept   (w_accept),
        .o_pick_i_c (w_pick_i),
        .o_pick_d_c (w_pick_d)
    );

    // Ownership FSM; mem_ready is only meaningful while a grant is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= GNT_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_i) begin
                        r_state <= S_GNT_I;
                        r_grant <= GNT_I;
                    end else if (w_pick_d) begin
                        r_state <= S_GNT_D;
                        r_grant <= GNT_D;
                    end
                end
                S_GNT_I: begin
                    if (mem_ready || !w_req_i) begin
                        r_state <= S_IDLE;
                        r_grant <= GNT_NONE;
                    end
                end
                S_GNT_D: begin
                    if (mem_ready || !w_req_d) begin
                        r_state <= S_IDLE;
                        r_grant <= GNT_NONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= GNT_NONE;
                end
            endcase
        end
    end

    // Downstream mux follows the owner combinationally, so an owner that
    // drops its request stops the memory request in the same cycle.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        case (r_state)
            S_GNT_I: begin
                mem_read    = i_mem_read;
                mem_write   = i_mem_write;
                mem_addr    = i_mem_addr;
                mem_wdata   = i_mem_wdata;
                i_mem_ready = mem_ready;
            end
            S_GNT_D: begin
                mem_read    = d_mem_read;
                mem_write   = d_mem_write;
                mem_addr    = d_mem_addr;
                mem_wdata   = d_mem_wdata;
                d_mem_ready = mem_ready;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; each cache qualifies it with its own ready.
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;
    assign grant       = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance (dut0) and a
// fixed-priority instance (dut1) sharing the same stimulus.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_rd, i_wr, d_rd, d_wr;
    logic [27:0]  i_addr, d_addr;
    logic [127:0] i_wd, d_wd;
    logic [127:0] m_rdata;
    logic         m_ready;

    logic         m_read, m_write, i_rdy, d_rdy;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata, i_rdata, d_rdata;
    logic [1:0]   gnt;

    logic         m1_read, m1_write, i1_rdy, d1_rdy;
    logic [27:0]  m1_addr;
    logic [127:0] m1_wdata, i1_rdata, d1_rdata;
    logic [1:0]   gnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIORITY(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_mem_read(i_rd), .i_mem_write(i_wr), .i_mem_addr(i_addr), .i_mem_wdata(i_wd),
        .i_mem_rdata(i_rdata), .i_mem_ready(i_rdy),
        .d_mem_read(d_rd), .d_mem_write(d_wr), .d_mem_addr(d_addr), .d_mem_wdata(d_wd),
        .d_mem_rdata(d_rdata), .d_mem_ready(d_rdy),
        .mem_read(m_read), .mem_write(m_write), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata), .mem_ready(m_ready), .grant(gnt)
    );

    mem_arbiter #(.FIXED_PRIORITY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_mem_read(i_rd), .i_mem_write(i_wr), .i_mem_addr(i_addr), .i_mem_wdata(i_wd),
        .i_mem_rdata(i1_rdata), .i_mem_ready(i1_rdy),
        .d_mem_read(d_rd), .d_mem_write(d_wr), .d_mem_addr(d_addr), .d_mem_wdata(d_wd),
        .d_mem_rdata(d1_rdata), .d_mem_ready(d1_rdy),
        .mem_read(m1_read), .mem_write(m1_write), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m_rdata), .mem_ready(m_ready), .grant(gnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkg(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_rd = 1'b0; i_wr = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; i_wd = '0; d_wd = '0;
        m_rdata = '0; m_ready = 1'b0;

        // Reset state
        step(); step();
        chkg("rst_grant", gnt, 2'b00);
        chkb("rst_mem_read", m_read, 1'b0);
        chkb("rst_mem_write", m_write, 1'b0);
        chkv("rst_mem_addr", 128'(m_addr), 128'h0);
        chkv("rst_mem_wdata", m_wdata, 128'h0);
        chkb("rst_i_ready", i_rdy, 1'b0);
        chkb("rst_d_ready", d_rdy, 1'b0);

        // I-only read, memory ready at cycle 5
        rst = 1'b0; i_rd = 1'b1; i_addr = 28'h0000010; #1;
        chkb("t1_c0_no_req_yet", m_read, 1'b0);
        step();
        chkb("t1_c1_mem_read", m_read, 1'b1);
        chkv("t1_c1_mem_addr", 128'(m_addr), 128'h10);
        chkg("t1_c1_grant", gnt, 2'b01);
        step(); step(); step();
        chkb("t1_c4_mem_read", m_read, 1'b1);
        chkb("t1_c4_i_ready", i_rdy, 1'b0);
        step(); m_ready = 1'b1; m_rdata = {16{8'hA5}}; #1;
        chkb("t1_c5_i_ready", i_rdy, 1'b1);
        chkb("t1_c5_d_ready", d_rdy, 1'b0);
        chkv("t1_c5_i_rdata", i_rdata, {16{8'hA5}});
        step(); m_ready = 1'b0; i_rd = 1'b0; #1;
        chkg("t1_c6_grant", gnt, 2'b00);
        chkb("t1_c6_mem_read", m_read, 1'b0);
        chkb("t1_c6_i_ready", i_rdy, 1'b0);

        // Tie after reset: I first, then next tie goes to D
        rst = 1'b1; step(); rst = 1'b0;
        i_rd = 1'b1; i_addr = 28'h10; d_wr = 1'b1; d_addr = 28'h20; d_wd = 128'h1234;
        step();
        chkg("t2_first_grant_i", gnt, 2'b01);
        chkv("t2_first_addr", 128'(m_addr), 128'h10);
        chkb("t2_first_no_write", m_write, 1'b0);
        m_ready = 1'b1; #1;
        chkb("t2_i_ready", i_rdy, 1'b1);
        chkb("t2_d_ready_quiet", d_rdy, 1'b0);
        step(); m_ready = 1'b0; i_addr = 28'h14; #1;
        chkg("t2_dead_grant", gnt, 2'b00);
        chkb("t2_dead_write", m_write, 1'b0);
        step();
        chkg("t2_tie2_grant_d", gnt, 2'b10);
        chkb("t2_d_write", m_write, 1'b1);
        chkb("t2_d_no_read", m_read, 1'b0);
        chkv("t2_d_addr", 128'(m_addr), 128'h20);
        chkv("t2_d_wdata", m_wdata, 128'h1234);
        m_ready = 1'b1; #1;
        chkb("t2_d_ready", d_rdy, 1'b1);
        chkb("t2_i_ready_quiet", i_rdy, 1'b0);
        step(); m_ready = 1'b0; d_wr = 1'b0; #1;
        chkg("t2_dead2_grant", gnt, 2'b00);
        step();
        chkg("t2_i_again_grant", gnt, 2'b01);
        chkv("t2_i_again_addr", 128'(m_addr), 128'h14);
        m_ready = 1'b1; #1;
        chkb("t2_i_again_ready", i_rdy, 1'b1);
        step(); m_ready = 1'b0; i_rd = 1'b0; #1;
        chkg("t2_end_grant", gnt, 2'b00);

        // D requests while I holds a 10-cycle transaction
        i_rd = 1'b1; i_addr = 28'h60;
        step();
        chkg("t3_c1_grant_i", gnt, 2'b01);
        step(); step(); d_rd = 1'b1; d_addr = 28'h70; #1;
        chkv("t3_c3_addr_held", 128'(m_addr), 128'h60);
        chkb("t3_c3_read_held", m_read, 1'b1);
        chkg("t3_c3_grant_held", gnt, 2'b01);
        chkb("t3_c3_d_ready", d_rdy, 1'b0);
        for (int k = 4; k <= 10; k++) begin
            step();
            chkb("t3_wait_d_ready", d_rdy, 1'b0);
            chkv("t3_wait_addr", 128'(m_addr), 128'h60);
        end
        step(); m_ready = 1'b1; #1;
        chkb("t3_c11_i_ready", i_rdy, 1'b1);
        chkb("t3_c11_d_ready", d_rdy, 1'b0);
        step(); m_ready = 1'b0; i_rd = 1'b0; #1;
        chkg("t3_dead_grant", gnt, 2'b00);
        chkb("t3_dead_read", m_read, 1'b0);
        step();
        chkg("t3_d_grant", gnt, 2'b10);
        chkv("t3_d_addr", 128'(m_addr), 128'h70);
        chkb("t3_d_read", m_read, 1'b1);
        m_ready = 1'b1; #1;
        chkb("t3_d_ready", d_rdy, 1'b1);
        step(); m_ready = 1'b0; d_rd = 1'b0; #1;
        chkg("t3_end_grant", gnt, 2'b00);

        // D write-back, then D fetch with I also waiting
        d_wr = 1'b1; d_addr = 28'h30;
        step();
        chkg("t4_wb_grant", gnt, 2'b10);
        chkb("t4_wb_write", m_write, 1'b1);
        chkv("t4_wb_addr", 128'(m_addr), 128'h30);
        i_rd = 1'b1; i_addr = 28'h80; m_ready = 1'b1; #1;
        chkb("t4_wb_d_ready", d_rdy, 1'b1);
        chkb("t4_wb_i_ready", i_rdy, 1'b0);
        step(); m_ready = 1'b0; d_wr = 1'b0; d_rd = 1'b1; d_addr = 28'h40; #1;
        chkg("t4_dead1_grant", gnt, 2'b00);
        chkb("t4_dead1_read", m_read, 1'b0);
        chkb("t4_dead1_write", m_write, 1'b0);
        step();
        chkg("t4_i_grant", gnt, 2'b01);
        chkv("t4_i_addr", 128'(m_addr), 128'h80);
        m_ready = 1'b1; #1;
        chkb("t4_i_ready", i_rdy, 1'b1);
        step(); m_ready = 1'b0; i_rd = 1'b0; #1;
        chkg("t4_dead2_grant", gnt, 2'b00);
        step();
        chkg("t4_fetch_grant", gnt, 2'b10);
        chkb("t4_fetch_read", m_read, 1'b1);
        chkb("t4_fetch_no_write", m_write, 1'b0);
        chkv("t4_fetch_addr", 128'(m_addr), 128'h40);
        m_ready = 1'b1; #1;
        chkb("t4_fetch_ready", d_rdy, 1'b1);
        step(); m_ready = 1'b0; d_rd = 1'b0; #1;
        chkg("t4_end_grant", gnt, 2'b00);

        // D aborts before ready; stray mem_ready afterwards
        d_rd = 1'b1; d_addr = 28'h90;
        step();
        chkg("t5_grant", gnt, 2'b10);
        chkb("t5_read", m_read, 1'b1);
        d_rd = 1'b0; #1;
        chkb("t5_abort_read_now", m_read, 1'b0);
        step();
        chkg("t5_abort_grant", gnt, 2'b00);
        m_ready = 1'b1; #1;
        chkb("t5_stray_d_ready", d_rdy, 1'b0);
        chkb("t5_stray_i_ready", i_rdy, 1'b0);
        step(); m_ready = 1'b0;

        // Reset pulsed while D owns the port
        d_wr = 1'b1; d_addr = 28'hA0;
        step();
        chkb("t6_write", m_write, 1'b1);
        rst = 1'b1;
        step();
        chkg("t6_rst_grant", gnt, 2'b00);
        chkb("t6_rst_write", m_write, 1'b0);
        m_ready = 1'b1; #1;
        chkb("t6_stray_d_ready", d_rdy, 1'b0);
        rst = 1'b0; d_wr = 1'b0;
        step(); m_ready = 1'b0; #1;
        chkb("t6_after_write", m_write, 1'b0);
        chkg("t6_after_grant", gnt, 2'b00);

        // Fixed priority: D wins every tie, I only when D is idle
        rst = 1'b1; step(); rst = 1'b0;
        i_rd = 1'b1; i_addr = 28'h10; d_rd = 1'b1; d_addr = 28'h20;
        step();
        chkg("fp_tie1_grant", gnt1, 2'b10);
        chkv("fp_tie1_addr", 128'(m1_addr), 128'h20);
        m_ready = 1'b1; #1;
        chkb("fp_tie1_d_ready", d1_rdy, 1'b1);
        chkb("fp_tie1_i_ready", i1_rdy, 1'b0);
        step(); m_ready = 1'b0; d_addr = 28'h24; #1;
        chkg("fp_dead1_grant", gnt1, 2'b00);
        step();
        chkg("fp_tie2_grant", gnt1, 2'b10);
        chkv("fp_tie2_addr", 128'(m1_addr), 128'h24);
        m_ready = 1'b1; #1;
        chkb("fp_tie2_d_ready", d1_rdy, 1'b1);
        step(); m_ready = 1'b0; d_rd = 1'b0; #1;
        chkg("fp_dead2_grant", gnt1, 2'b00);
        step();
        chkg("fp_i_grant", gnt1, 2'b01);
        chkv("fp_i_addr", 128'(m1_addr), 128'h10);
        m_ready = 1'b1; #1;
        chkb("fp_i_ready", i1_rdy, 1'b1);
        step(); m_ready = 1'b0; i_rd = 1'b0; #1;
        chkg("fp_end_grant", gnt1, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
